// File: rtl/joy_resp_pkg.sv
// Shared types and default sizes for the DB15 joystick responder.
// Build option JOY_RESP_TIMEOUT_EN adds a shift-phase inactivity abort.
package joy_resp_pkg;

  localparam int BTN_W_DEF       = 12;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } joy_state_e;

endpackage

// File: rtl/joy_db15_responder_sync_edge.sv
// Two-flop synchronizer with rise/fall detect on the synchronized level.
// Resets to a high level so an idle host line never looks like an edge.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/joy_db15_responder.sv
// DB15 two-player joystick shift-register responder for a host poller.
// Define JOY_RESP_TIMEOUT_EN to abort a stalled shift after TIMEOUT_CYC.
module joy_db15_responder
  import joy_resp_pkg::*;
#(
  parameter int BTN_W       = BTN_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             CLK,
  input  logic             I_RESET_L,
  input  logic [BTN_W-1:0] I_BTN_P1,
  input  logic [BTN_W-1:0] I_BTN_P2,
  input  logic             JOY_CLK,
  input  logic             JOY_LOAD,
  output logic             JOY_DATA,
  output logic             O_BUSY
);

  localparam int FL = 2 * BTN_W;
  localparam int CW = $clog2(FL + 1);
  localparam logic [CW-1:0] FL_C = CW'(FL);

  logic jclk_rise;
  logic load_lvl;
  logic load_rise;

  sync_edge u_sync_clk (
    .clk    (CLK),
    .rst_n  (I_RESET_L),
    .d_i    (JOY_CLK),
    .lvl_o  (),
    .rise_o (jclk_rise),
    .fall_o ()
  );

  sync_edge u_sync_load (
    .clk    (CLK),
    .rst_n  (I_RESET_L),
    .d_i    (JOY_LOAD),
    .lvl_o  (load_lvl),
    .rise_o (load_rise),
    .fall_o ()
  );

  joy_state_e     state_q, state_d;
  logic [FL-1:0]  sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           data_q, data_d;
  logic [FL-1:0]  frame;
  logic [CW-1:0]  cnt_inc;

`ifdef JOY_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign frame   = ~{I_BTN_P2, I_BTN_P1};
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef JOY_RESP_TIMEOUT_EN
    tmo_d   = '0;
`endif
    // A low load strobe wins over everything, including a clock edge.
    if (!load_lvl) begin
      state_d = ST_LOAD;
      sr_d    = frame;
      cnt_d   = '0;
      data_d  = frame[0];
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          data_d = 1'b1;
        end
        ST_LOAD: begin
          data_d = sr_q[0];
          if (load_rise) begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (jclk_rise && cnt_q != FL_C) begin
            sr_d  = {1'b1, sr_q[FL-1:1]};
            cnt_d = cnt_inc;
            if (cnt_inc == FL_C) begin
              state_d = ST_DONE;
              data_d  = 1'b1;
            end else begin
              data_d = sr_q[1];
            end
          end
`ifdef JOY_RESP_TIMEOUT_EN
          if (!jclk_rise) begin
            if (tmo_q == TMO_LAST) begin
              state_d = ST_IDLE;
              data_d  = 1'b1;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
`endif
        end
        ST_DONE: begin
          data_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          data_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q <= ST_IDLE;
      sr_q    <= '1;
      cnt_q   <= '0;
      data_q  <= 1'b1;
`ifdef JOY_RESP_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef JOY_RESP_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign JOY_DATA = data_q;
  assign O_BUSY   = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_joy_db15_responder.sv
// Directed and randomized frames checked against a frame-level model.
// Optional build JOY_RESP_TIMEOUT_EN changes the expected stall result.
module tb_joy_db15_responder;

  localparam int BW = 12;
  localparam int FLEN = 2 * BW;

  logic          CLK = 1'b0;
  logic          I_RESET_L = 1'b0;
  logic [BW-1:0] I_BTN_P1 = '0;
  logic [BW-1:0] I_BTN_P2 = '0;
  logic          JOY_CLK = 1'b0;
  logic          JOY_LOAD = 1'b1;
  logic          JOY_DATA;
  logic          O_BUSY;

  int checks = 0;
  int errors = 0;

  joy_db15_responder #(
    .BTN_W       (BW),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK       (CLK),
    .I_RESET_L (I_RESET_L),
    .I_BTN_P1  (I_BTN_P1),
    .I_BTN_P2  (I_BTN_P2),
    .JOY_CLK   (JOY_CLK),
    .JOY_LOAD  (JOY_LOAD),
    .JOY_DATA  (JOY_DATA),
    .O_BUSY    (O_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Host sees bit k of the inverted button word after k edges, then idle-high.
  function automatic logic exp_bit(input logic [FLEN-1:0] f, input int k);
    return (k < FLEN) ? f[k] : 1'b1;
  endfunction

  function automatic logic exp_busy(input int k);
    return (k < FLEN) ? 1'b1 : 1'b0;
  endfunction

  task automatic do_load(output logic [FLEN-1:0] f);
    f = ~{I_BTN_P2, I_BTN_P1};
    JOY_LOAD = 1'b0;
    tick(6);
    chk("load_data", 32'(JOY_DATA), 32'(f[0]));
    chk("load_busy", 32'(O_BUSY), 32'd1);
    JOY_LOAD = 1'b1;
    tick(6);
  endtask

  task automatic pulse();
    JOY_CLK = 1'b1;
    tick(4);
    JOY_CLK = 1'b0;
    tick(4);
  endtask

  task automatic shift_check(input string tag, input logic [FLEN-1:0] f,
                             input int first, input int last,
                             input bit scramble);
    for (int k = first; k <= last; k++) begin
      pulse();
      if (scramble) begin
        I_BTN_P1 = BW'($urandom);
        I_BTN_P2 = BW'($urandom);
      end
      chk({tag, "_bit"}, 32'(JOY_DATA), 32'(exp_bit(f, k)));
      chk({tag, "_busy"}, 32'(O_BUSY), 32'(exp_busy(k)));
    end
  endtask

  initial begin
    logic [FLEN-1:0] f;

    // reset state and quiet host
    tick(3);
    chk("rst_data", 32'(JOY_DATA), 32'd1);
    chk("rst_busy", 32'(O_BUSY), 32'd0);
    I_RESET_L = 1'b1;
    tick(50);
    chk("idle_data", 32'(JOY_DATA), 32'd1);
    chk("idle_busy", 32'(O_BUSY), 32'd0);

    // directed frame with both end bits pressed, extra edges ignored
    I_BTN_P1 = 12'h001;
    I_BTN_P2 = 12'h800;
    do_load(f);
    chk("dir_b0", 32'(JOY_DATA), 32'd0);
    shift_check("dir", f, 1, 30, 1'b0);

    // reload after 10 edges restarts from bit 0
    I_BTN_P1 = 12'h5A3;
    I_BTN_P2 = 12'h0F6;
    do_load(f);
    shift_check("pre", f, 1, 10, 1'b0);
    I_BTN_P1 = 12'h3C1;
    I_BTN_P2 = 12'hA0E;
    f = ~{I_BTN_P2, I_BTN_P1};
    JOY_LOAD = 1'b0;
    JOY_CLK = 1'b1;
    tick(3);
    chk("reload_data", 32'(JOY_DATA), 32'(f[0]));
    chk("reload_busy", 32'(O_BUSY), 32'd1);
    JOY_CLK = 1'b0;
    tick(3);
    JOY_LOAD = 1'b1;
    tick(6);
    shift_check("reload", f, 1, 24, 1'b0);

    // randomized frames, buttons changing while shifting
    for (int n = 0; n < 4; n++) begin
      I_BTN_P1 = BW'($urandom);
      I_BTN_P2 = BW'($urandom);
      do_load(f);
      shift_check("rnd", f, 1, 25, 1'b1);
    end

    // stalled host after 3 edges
    I_BTN_P1 = 12'h000;
    I_BTN_P2 = 12'h000;
    do_load(f);
    repeat (3) pulse();
    tick(20);
`ifdef JOY_RESP_TIMEOUT_EN
    chk("tmo_busy", 32'(O_BUSY), 32'd0);
    chk("tmo_data", 32'(JOY_DATA), 32'd1);
`else
    chk("stall_busy", 32'(O_BUSY), 32'd1);
    chk("stall_data", 32'(JOY_DATA), 32'(f[3]));
`endif

    // async reset at edge 12 aborts the frame
    I_BTN_P1 = 12'hFFF;
    I_BTN_P2 = 12'hFFF;
    do_load(f);
    shift_check("prerst", f, 1, 12, 1'b0);
    I_RESET_L = 1'b0;
    #1;
    chk("arst_data", 32'(JOY_DATA), 32'd1);
    chk("arst_busy", 32'(O_BUSY), 32'd0);
    tick(2);
    I_RESET_L = 1'b1;
    tick(4);
    for (int k = 0; k < 6; k++) begin
      pulse();
      chk("post_data", 32'(JOY_DATA), 32'd1);
      chk("post_busy", 32'(O_BUSY), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
